cam_eth_arbiter: RTL and testbench

//   Shares the single GMII/UDP line sender between two camera capture paths (cam0, cam1) in the
//   eth clock domain. Queues "line ready" events per camera, chooses the next camera per mode,

---
 rtl/cam_eth_arb_pkg.sv | 16 +
 rtl/arb_flag_fifo.sv | 51 +++++
 rtl/cam_eth_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cam_eth_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_eth_arb_pkg.sv
// Shared types and mode encodings for the camera-to-Ethernet line arbiter.
package cam_eth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY,
    GAP
  } arb_state_e;

  localparam logic [1:0] MODE_CAM0  = 2'd0;
  localparam logic [1:0] MODE_CAM1  = 2'd1;
  localparam logic [1:0] MODE_RR    = 2'd2;
  localparam logic [1:0] MODE_FRAME = 2'd3;

endpackage

// File: rtl/arb_flag_fifo.sv
// Per-camera queue of pending line flags {first,last}; synchronous, power-of-2 deep.
module arb_flag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [1:0]               din_i,
  output logic [1:0]               dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees a slot in the same cycle, so a full queue still accepts a push then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cam_eth_arbiter.sv
// Arbitrates the single UDP line sender between two camera capture paths:
// queue line-ready events, pick a camera per mode, issue a command, wait, enforce the gap.
module cam_eth_arbiter
  import cam_eth_arb_pkg::*;
#(
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned IFG_CYC  = 12,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [1:0] line_rdy,
  input  logic [1:0] line_first,
  input  logic [1:0] line_last,
  output logic       send_start,
  output logic       send_sel,
  output logic       send_first,
  output logic       send_last,
  input  logic       send_done,
  output logic       busy,
  output logic [1:0] ovf,
  output logic       err_timeout
);

  localparam int unsigned CW = $clog2(MAX_PEND) + 1;

  arb_state_e      state_q, state_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [7:0]      gap_q, gap_d;
  logic            sel_q, sel_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            last_srv_q, last_srv_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;
  logic [1:0]      ovf_q, ovf_d;

  logic [1:0]      pop;
  logic [1:0]      empty;
  logic [1:0]      full;
  logic [1:0][1:0] head;
  logic [CW-1:0]   cnt0, cnt1;
  logic            grant;
  logic            gcam;
  logic            other_pending;

  arb_flag_fifo #(.DEPTH(MAX_PEND)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (line_rdy[0]),
    .pop_i   (pop[0]),
    .din_i   ({line_first[0], line_last[0]}),
    .dout_o  (head[0]),
    .count_o (cnt0),
    .full_o  (full[0]),
    .empty_o (empty[0])
  );

  arb_flag_fifo #(.DEPTH(MAX_PEND)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (line_rdy[1]),
    .pop_i   (pop[1]),
    .din_i   ({line_first[1], line_last[1]}),
    .dout_o  (head[1]),
    .count_o (cnt1),
    .full_o  (full[1]),
    .empty_o (empty[1])
  );

  assign other_pending = gcam ? (cnt0 != '0) : (cnt1 != '0);

  always_comb begin
    grant = 1'b0;
    gcam  = 1'b0;
    case (mode)
      MODE_CAM0: begin
        grant = ~empty[0];
        gcam  = 1'b0;
      end
      MODE_CAM1: begin
        grant = ~empty[1];
        gcam  = 1'b1;
      end
      MODE_RR: begin
        grant = ~&empty;
        gcam  = (empty == 2'b00) ? ~last_srv_q : empty[0];
      end
      default: begin
        // Frame interleave: stay on the locked camera; hop only onto a frame start.
        if (!empty[lock_q]) begin
          grant = 1'b1;
          gcam  = lock_q;
        end else if (!empty[~lock_q] && head[~lock_q][1]) begin
          grant = 1'b1;
          gcam  = ~lock_q;
        end
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    sel_d      = sel_q;
    first_d    = first_q;
    last_d     = last_q;
    last_srv_d = last_srv_q;
    lock_d     = lock_q;
    err_d      = err_q;
    pop        = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d           = GRANT;
          pop[gcam]         = 1'b1;
          sel_d             = gcam;
          {first_d, last_d} = head[gcam];
          last_srv_d        = gcam;
          if (mode == MODE_FRAME) lock_d = (head[gcam][0] && other_pending) ? ~gcam : gcam;
        end
      end
      GRANT: begin
        state_d = BUSY;
        tmo_d   = '0;
      end
      BUSY: begin
        if (send_done) begin
          state_d = GAP;
          gap_d   = '0;
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          state_d = GAP;
          gap_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        if (gap_q == 8'(IFG_CYC - 1)) state_d = IDLE;
        else                          gap_d   = gap_q + 8'd1;
      end
    endcase
    ovf_d = ovf_q | (line_rdy & full & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      gap_q      <= '0;
      sel_q      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      last_srv_q <= 1'b1;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      sel_q      <= sel_d;
      first_q    <= first_d;
      last_q     <= last_d;
      last_srv_q <= last_srv_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign send_start  = (state_q == GRANT);
  assign busy        = (state_q != IDLE);
  assign send_sel    = sel_q;
  assign send_first  = first_q;
  assign send_last   = last_q;
  assign ovf         = ovf_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_cam_eth_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_cam_eth_arbiter;

  localparam int unsigned MAXP = 4;
  localparam int          IFG  = 12;
  localparam int          TO   = 100;
  localparam int          INF  = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] line_rdy = '0;
  logic [1:0] line_first = '0;
  logic [1:0] line_last = '0;
  logic       send_done = 1'b0;
  logic       send_start, send_sel, send_first, send_last, busy, err_timeout;
  logic [1:0] ovf;

  int errors = 0;
  int checks = 0;

  cam_eth_arbiter #(.MAX_PEND(MAXP), .IFG_CYC(IFG), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .line_rdy    (line_rdy),
    .line_first  (line_first),
    .line_last   (line_last),
    .send_start  (send_start),
    .send_sel    (send_sel),
    .send_first  (send_first),
    .send_last   (send_last),
    .send_done   (send_done),
    .busy        (busy),
    .ovf         (ovf),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: per-camera queues plus the timestamps of the current packet.
  logic [1:0] mq0[$];
  logic [1:0] mq1[$];
  int         cyc;
  bit         m_active;
  int         g_t;
  int         end_t;
  int         m_last;
  int         m_lock;
  logic       e_sel, e_first, e_last, e_err;
  logic [1:0] e_ovf;

  int snd_lat;
  int stray_t;
  bit stray_en;
  int starts;
  int grant_log[$];

  function automatic int qsize(input int c);
    return (c == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [1:0] qhead(input int c);
    return (c == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    cyc      = 0;
    m_active = 0;
    g_t      = 0;
    end_t    = INF;
    m_last   = 1;
    m_lock   = 0;
    e_sel    = 0;
    e_first  = 0;
    e_last   = 0;
    e_err    = 0;
    e_ovf    = '0;
    stray_t  = -1;
  endtask

  task automatic check_outputs();
    logic e_start, e_busy;
    e_start = m_active && (cyc == g_t);
    e_busy  = m_active && (cyc >= g_t) && (cyc < end_t);
    chk("send_start", send_start, e_start);
    chk("busy", busy, e_busy);
    chk("send_sel", send_sel, e_sel);
    chk("send_first", send_first, e_first);
    chk("send_last", send_last, e_last);
    chk("ovf", ovf, e_ovf);
    chk("err_timeout", err_timeout, e_err);
    if (send_start === 1'b1) begin
      starts++;
      grant_log.push_back(int'(send_sel));
    end
  endtask

  task automatic model_advance(input logic [1:0] rdy, input logic [1:0] fst,
                               input logic [1:0] lst, input logic done);
    int         c;
    int         o;
    logic [1:0] v;
    logic [1:0] h;
    if (m_active && cyc > g_t && end_t == INF) begin
      if (done) end_t = cyc + 1 + IFG;
      else if (cyc == g_t + TO) begin
        end_t = cyc + 1 + IFG;
        e_err = 1'b1;
      end
    end
    if (!m_active || cyc >= end_t) begin
      c = -1;
      case (mode)
        2'd0: if (qsize(0) > 0) c = 0;
        2'd1: if (qsize(1) > 0) c = 1;
        2'd2: begin
          if (qsize(0) > 0 && qsize(1) > 0) c = 1 - m_last;
          else if (qsize(0) > 0)            c = 0;
          else if (qsize(1) > 0)            c = 1;
        end
        default: begin
          o = 1 - m_lock;
          if (qsize(m_lock) > 0) c = m_lock;
          else if (qsize(o) > 0) begin
            h = qhead(o);
            if (h[1]) c = o;
          end
        end
      endcase
      if (c >= 0) begin
        v = (c == 0) ? mq0.pop_front() : mq1.pop_front();
        e_sel   = (c == 1);
        e_first = v[1];
        e_last  = v[0];
        m_last  = c;
        if (mode == 2'd3) m_lock = (v[0] && qsize(1 - c) > 0) ? 1 - c : c;
        m_active = 1;
        g_t      = cyc + 1;
        end_t    = INF;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rdy[i]) begin
        if (qsize(i) < int'(MAXP)) begin
          if (i == 0) mq0.push_back({fst[i], lst[i]});
          else        mq1.push_back({fst[i], lst[i]});
        end else e_ovf[i] = 1'b1;
      end
    end
    cyc++;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance both.
  task automatic step(input logic [1:0] rdy, input logic [1:0] fst,
                      input logic [1:0] lst, input logic xdone);
    logic auto_done;
    auto_done = (snd_lat > 0) && m_active && (cyc == g_t + snd_lat);
    if (auto_done && stray_en) stray_t = cyc + 5;
    line_rdy   = rdy;
    line_first = fst;
    line_last  = lst;
    send_done  = xdone | auto_done | (cyc == stray_t);
    check_outputs();
    model_advance(rdy, fst, lst, send_done);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    line_rdy   = '0;
    line_first = '0;
    line_last  = '0;
    send_done  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_send_start", send_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_send_sel", send_sel, 0);
    chk("rst_send_first", send_first, 0);
    chk("rst_send_last", send_last, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err_timeout", err_timeout, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    starts = 0;
    grant_log.delete();
  endtask

  initial begin : main
    int exp_m3[5];
    logic [1:0] r, f, l;
    exp_m3 = '{0, 0, 0, 1, 1};
    snd_lat  = 5;
    stray_en = 0;
    do_reset();

    // Round-robin: simultaneous arrivals, cam0 wins the first tie; stray done lands in the gap.
    mode = 2'd2;
    stray_en = 1;
    f = 2'($urandom);
    l = 2'($urandom);
    step(2'b11, f, l, 1'b0);
    idle(45);
    chk("rr_starts", starts, 2);
    if (grant_log.size() == 2) begin
      chk("rr_first_sel", grant_log[0], 0);
      chk("rr_second_sel", grant_log[1], 1);
    end
    stray_en = 0;

    // Cam0 only, sender silent: overflow after the queue fills, then timeout.
    do_reset();
    mode = 2'd0;
    snd_lat = 0;
    step(2'b01, 2'b01, 2'b00, 1'b0);
    idle(2);
    repeat (5) step(2'b01, 2'b00, 2'b00, 1'b0);
    idle(3);
    chk("m0_ovf", ovf, 2'b01);
    chk("m0_one_start", starts, 1);
    snd_lat = 3;
    idle(200);
    chk("m0_timeout_flag", err_timeout, 1);
    chk("m0_drained_starts", starts, 5);

    // Frame interleave: whole cam0 frame first, then the cam1 frame.
    do_reset();
    mode = 2'd3;
    snd_lat = 4;
    step(2'b01, 2'b01, 2'b00, 1'b0);
    step(2'b10, 2'b10, 2'b00, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0);
    step(2'b10, 2'b00, 2'b10, 1'b0);
    step(2'b01, 2'b00, 2'b01, 1'b0);
    idle(120);
    chk("m3_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk($sformatf("m3_grant%0d", i), grant_log[i], exp_m3[i]);

    // Reset while busy with three lines still queued.
    do_reset();
    mode = 2'd0;
    snd_lat = 0;
    repeat (4) step(2'b01, 2'b00, 2'b00, 1'b0);
    idle(10);
    chk("mid_busy", busy, 1);
    do_reset();
    idle(40);
    chk("post_reset_starts", starts, 0);

    // Random traffic with mode changes, varied sender latency and spurious done pulses.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 0) begin
        mode    = 2'($urandom_range(0, 3));
        snd_lat = $urandom_range(0, 25);
      end
      r[0] = ($urandom_range(0, 5) == 0);
      r[1] = ($urandom_range(0, 5) == 0);
      f = 2'($urandom);
      l = 2'($urandom);
      step(r, f, l, ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
